// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED mode encodings and mode decode helper
package led_pkg;

    typedef enum logic [2:0] {
        MODE_OFF  = 3'd0,
        MODE_SLOW = 3'd1,
        MODE_FAST = 3'd2,
        MODE_ON   = 3'd3,
        MODE_ACT  = 3'd4,
        MODE_NACT = 3'd5
    } led_mode_e;

    // Encodings 6 and 7 are reserved and read as off.
    function automatic logic decode_mode(
        input logic [2:0] mode,
        input logic       slow_tap,
        input logic       fast_tap,
        input logic       flash
    );
        logic lit;
        case (mode)
            MODE_SLOW: lit = slow_tap;
            MODE_FAST: lit = fast_tap;
            MODE_ON:   lit = 1'b1;
            MODE_ACT:  lit = flash;
            MODE_NACT: lit = ~flash;
            default:   lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/led_pulse_stretch.sv
// rtl/led_pulse_stretch.sv - retriggerable stretcher turning 1-clock activity strobes into visible flashes
module led_pulse_stretch #(
    parameter int STRETCH_CYC = 4194304
) (
    input  logic clk,
    input  logic rst,
    input  logic act,
    output logic active
);

    localparam int CNT_W = $clog2(STRETCH_CYC + 1);

    logic [CNT_W-1:0] cnt;

    // A strobe always reloads, even on the clock the count would reach zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (act) begin
            cnt <= CNT_W'(STRETCH_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign active = (cnt != '0);

endmodule

// File: rtl/led_matrix_ctrl.sv
// rtl/led_matrix_ctrl.sv - row-scanned LED matrix driver with blink/activity modes and PWM dimming
module led_matrix_ctrl
    import led_pkg::*;
#(
    parameter int NUM_ROWS    = 4,
    parameter int NUM_COLS    = 4,
    parameter int SCAN_DIV    = 16384,
    parameter int BLANK_CYC   = 64,
    parameter int DUTY_W      = 4,
    parameter int SLOW_BIT    = 28,
    parameter int FAST_BIT    = 24,
    parameter int STRETCH_CYC = 4194304,
    parameter bit ROW_ACT_LOW = 1'b1,
    parameter bit COL_ACT_LOW = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [DUTY_W-1:0]                brightness,
    input  logic [3*NUM_ROWS*NUM_COLS-1:0]   led_mode,
    input  logic [NUM_ROWS*NUM_COLS-1:0]     act,
    output logic [NUM_COLS-1:0]              scan_x,
    output logic [NUM_ROWS-1:0]              scan_y
);

    localparam int NLED   = NUM_ROWS * NUM_COLS;
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int ROW_W  = $clog2(NUM_ROWS);

    logic [SLOW_BIT:0]   timer;
    logic [SLOT_W-1:0]   slot;
    logic [ROW_W-1:0]    row;
    logic [NLED-1:0]     flash;
    logic                pwm_on;
    logic [NUM_COLS-1:0] col_on;
    logic [NUM_ROWS-1:0] row_on;

    for (genvar i = 0; i < NLED; i++) begin : g_led
        led_pulse_stretch #(
            .STRETCH_CYC(STRETCH_CYC)
        ) u_stretch (
            .clk   (clk),
            .rst   (rst),
            .act   (act[i]),
            .active(flash[i])
        );
    end

    // The low slot bits double as the PWM phase; the blank window guards row changeover.
    always_comb begin
        col_on = '0;
        row_on = en ? (NUM_ROWS'(1) << row) : '0;
        pwm_on = en && (int'(slot) >= BLANK_CYC) && (slot[DUTY_W-1:0] < brightness);
        for (int c = 0; c < NUM_COLS; c++) begin
            col_on[c] = pwm_on && decode_mode(led_mode[3*(int'(row)*NUM_COLS + c) +: 3],
                                              timer[SLOW_BIT], timer[FAST_BIT],
                                              flash[int'(row)*NUM_COLS + c]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer  <= '0;
            slot   <= '0;
            row    <= '0;
            scan_x <= {NUM_COLS{COL_ACT_LOW}};
            scan_y <= {NUM_ROWS{ROW_ACT_LOW}};
        end else begin
            timer <= timer + 1'b1;
            slot  <= slot + 1'b1;
            if (slot == SLOT_W'(SCAN_DIV - 1)) begin
                row <= (row == ROW_W'(NUM_ROWS - 1)) ? '0 : row + 1'b1;
            end
            scan_x <= col_on ^ {NUM_COLS{COL_ACT_LOW}};
            scan_y <= row_on ^ {NUM_ROWS{ROW_ACT_LOW}};
        end
    end

endmodule

// File: tb/tb_led_matrix_ctrl.sv
// tb/tb_led_matrix_ctrl.sv - scoreboard bench for led_matrix_ctrl
module tb_led_matrix_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  brightness = 2'd0;
    logic [47:0] led_mode = '0;
    logic [15:0] act = '0;
    logic [3:0]  scan_x;
    logic [3:0]  scan_y;

    led_matrix_ctrl #(
        .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(16), .BLANK_CYC(2), .DUTY_W(2),
        .SLOW_BIT(8), .FAST_BIT(6), .STRETCH_CYC(20),
        .ROW_ACT_LOW(1'b1), .COL_ACT_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .brightness(brightness),
        .led_mode(led_mode), .act(act), .scan_x(scan_x), .scan_y(scan_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    s = 0;
    int    act_at[16];
    string phase = "reset";
    bit    drv_done = 1'b0;

    // s counts clocks since reset release; slot, row and timer follow from it directly.
    function automatic exp_t expect_out();
        exp_t       e;
        logic [3:0] one;
        int         slot, row, tm, m, i;
        bit         on, fl;
        one   = 4'b0001;
        e.tag = phase;
        e.x   = 4'b0000;
        e.y   = 4'b1111;
        if (!rst) return e;
        slot = s % 16;
        row  = (s / 16) % 4;
        tm   = s % 512;
        if (en) e.y = ~(one << row);
        if (en && slot >= 2 && (slot % 4) < int'(brightness)) begin
            for (int c = 0; c < 4; c++) begin
                i  = row * 4 + c;
                m  = int'(led_mode[3*i +: 3]);
                fl = (s > act_at[i]) && (s <= act_at[i] + 20);
                case (m)
                    1:       on = ((tm >> 8) & 1) == 1;
                    2:       on = ((tm >> 6) & 1) == 1;
                    3:       on = 1'b1;
                    4:       on = fl;
                    5:       on = !fl;
                    default: on = 1'b0;
                endcase
                e.x[c] = on;
            end
        end
        return e;
    endfunction

    task automatic step();
        sb.push_back(expect_out());
        if (rst) begin
            for (int i = 0; i < 16; i++) if (act[i]) act_at[i] = s;
            s++;
        end else begin
            s = 0;
            for (int i = 0; i < 16; i++) act_at[i] = -1000;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse(input logic [15:0] mask);
        act = mask;
        step();
        act = '0;
    endtask

    task automatic set_all(input logic [2:0] m);
        for (int i = 0; i < 16; i++) led_mode[3*i +: 3] = m;
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (scan_x !== e.x || scan_y !== e.y) begin
                    errors++;
                    $display("FAIL %s t=%0t: scan_x=%b scan_y=%b expected scan_x=%b scan_y=%b",
                             e.tag, $time, scan_x, scan_y, e.x, e.y);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) act_at[i] = -1000;
        @(negedge clk);
        en = 1'b1;
        brightness = 2'd3;
        set_all(3'd3);
        run(3);

        phase = "all_on";
        rst = 1'b1;
        run(71);

        phase = "async_reset";
        rst = 1'b0;
        #1;
        checks++;
        if (scan_y !== 4'b1111 || scan_x !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: scan_x=%b scan_y=%b expected scan_x=0000 scan_y=1111", scan_x, scan_y);
        end
        run(2);
        phase = "post_reset";
        rst = 1'b1;
        run(24);

        phase = "bright1";
        brightness = 2'd1;
        run(40);
        phase = "bright0";
        brightness = 2'd0;
        run(32);

        phase = "mixed_modes";
        brightness = 2'd3;
        for (int i = 0; i < 16; i++) led_mode[3*i +: 3] = 3'(i % 8);
        run(64);

        phase = "blink";
        set_all(3'd0);
        led_mode[2:0] = 3'd1;
        led_mode[5:3] = 3'd2;
        run(600);

        phase = "activity";
        set_all(3'd0);
        led_mode[17:15] = 3'd4;
        while (s % 64 != 14) step();
        pulse(16'h0020);
        run(14);
        pulse(16'h0020);
        run(60);

        phase = "act_at_expiry";
        while (s % 64 != 12) step();
        pulse(16'h0020);
        run(19);
        pulse(16'h0020);
        run(50);

        phase = "inverse_activity";
        led_mode[17:15] = 3'd5;
        while (s % 64 != 14) step();
        pulse(16'h0020);
        run(60);

        phase = "all_activity";
        set_all(3'd4);
        pulse(16'hFFFF);
        run(70);

        phase = "enable";
        set_all(3'd3);
        en = 1'b0;
        run(40);
        en = 1'b1;
        run(40);

        drv_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!drv_done && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (!drv_done || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: driver_done=%0d pending=%0d expected driver_done=1 pending=0",
                     drv_done, sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_matrix_ctrl.md
LED_MATRIX_CTRL -- requirements
Module: led_matrix_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 4, number of scanned rows (2..16).
REQ-002 SHALL have parameter NUM_COLS, default 4, number of columns driven per row (1..16).
REQ-003 SHALL have parameter SCAN_DIV, default 16384, clocks per row slot (power of two, at least 2^DUTY_W).
REQ-004 SHALL have parameter BLANK_CYC, default 64, anti-ghost blank clocks at the start of each row slot (less than SCAN_DIV).
REQ-005 SHALL have parameter DUTY_W, default 4, brightness width.
REQ-006 SHALL have parameter SLOW_BIT, default 28, and FAST_BIT, default 24, blink timer tap bits.
REQ-007 SHALL have parameter STRETCH_CYC, default 2^22, activity flash length in clocks.
REQ-008 SHALL have parameter ROW_ACT_LOW, default 1, and COL_ACT_LOW, default 0, output polarities.
REQ-009 SHALL have port clk, input, 1, single clock for all logic.
REQ-010 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-011 SHALL have port en, input, 1, display enable.
REQ-012 SHALL have port brightness, input, DUTY_W, global duty level.
REQ-013 SHALL have port led_mode, input, 3*NUM_ROWS*NUM_COLS, per-LED mode; LED i = row*NUM_COLS+col uses bits [3i+2:3i].
REQ-014 SHALL have port act, input, NUM_ROWS*NUM_COLS, per-LED activity strobe, 1-clock pulses.
REQ-015 SHALL have port scan_x, output reg, NUM_COLS, column drive.
REQ-016 SHALL have port scan_y, output reg, NUM_ROWS, one-hot row select.

Function
REQ-017 SHALL run a free-running blink timer, width SLOW_BIT+1, incremented every clock, wrapping to 0.
REQ-018 SHALL run a slot counter 0..SCAN_DIV-1; at wrap the row index SHALL advance by one, wrapping from NUM_ROWS-1 to 0.
REQ-019 SHALL decode modes: 0 off; 1 slow = timer[SLOW_BIT]; 2 fast = timer[FAST_BIT]; 3 on; 4 activity = stretch active; 5 inverse activity = not stretch active; 6-7 off.
REQ-020 SHALL implement a per-LED stretch counter that loads STRETCH_CYC on act=1, retriggers on any act during a flash, decrements to 0, and is active while nonzero.
REQ-021 SHALL assert column c active when en=1 AND slot >= BLANK_CYC AND slot[DUTY_W-1:0] < brightness AND the decoded state of LED (row,c) is 1.
REQ-022 SHALL produce zero output at brightness=0; at brightness=2^DUTY_W-1 SHALL produce duty of (2^DUTY_W-1)/2^DUTY_W within the unblanked region.
REQ-023 SHALL drive scan_y with only the current row active and all other rows inactive; with en=0, scan_y and scan_x SHALL be all inactive while the counters keep running.
REQ-024 SHALL apply polarity so that active means 0 when *_ACT_LOW=1, else 1.
REQ-025 SHALL register both outputs: they reflect the slot, row, timer, stretch and inputs of the previous clock (1-clock latency).
REQ-026 SHALL sample led_mode and brightness every clock without a handshake; a change SHALL be visible on the next output update.
REQ-027 SHALL, on simultaneous act and counter expiry, reload the counter (act wins).

Reset
REQ-028 SHALL, while rst=0, hold scan_x and scan_y all inactive (per polarity) and clear blink timer, slot counter, row index and all stretch counters to 0.
REQ-029 SHALL, on the first clock after rst release, present row 0 slot 0, which is blanked.
REQ-030 SHALL treat reset asserted mid-slot or mid-flash as immediate, with no completion of the current flash.

Structure
REQ-031 SHALL take the mode encodings (MODE_OFF, MODE_SLOW, MODE_FAST, MODE_ON, MODE_ACT, MODE_NACT) from shared package led_pkg.
REQ-032 SHALL instantiate one sub-module led_pulse_stretch (parameter STRETCH_CYC) per LED via generate.

Verification
Sim params: ROWS=4, COLS=4, SCAN_DIV=16, BLANK_CYC=2, DUTY_W=2, SLOW_BIT=8, FAST_BIT=6, STRETCH_CYC=20, defaults for polarity.
REQ-033 SHALL cover reset: rst=0 mid-scan -> scan_y=4'b1111 and scan_x=4'b0000 immediately; after release row 0 is reached with scan_y=4'b1110 and scan_x=0 for 2 clocks.
REQ-034 SHALL cover all-on: all modes=3, brightness=3, en=1 -> in each 16-clock slot scan_x=4'b1111 on 14 minus 4 = 10 clocks (slot[1:0]!=3, slot>=2); rows cycle 1110,1101,1011,0111.
REQ-035 SHALL cover brightness: brightness=1 -> scan_x active only where slot[1:0]==0 and slot>=2 (slots 4,8,12); brightness=0 -> never active.
REQ-036 SHALL cover blink: LED0 mode 1 -> active only while timer[8]=1 (256-clock half-period); LED1 mode 2 -> 64-clock half-period.
REQ-037 SHALL cover activity: LED5 mode 4, act[5] pulse -> col 1 lit in row 1 slots for 20 clocks; a second pulse at clock 15 extends to clock 35; mode 5 shows the complement.
REQ-038 SHALL cover enable: en=0 -> outputs inactive; on en=1 the scan resumes at the running row without a restart.
